alu_mul_seq: RTL and testbench



---
 rtl/alu_mul_pkg.sv | 16 +
 rtl/alu_mul_seq.sv | 128 ++++++++++++
 tb/tb_alu_mul_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_pkg.sv
// alu_mul_pkg: shared FSM encoding and sizing constants for the sequential AVR multiplier. Rev 1.0
`default_nettype none

package alu_mul_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  localparam int         OPW_DEF   = 8;
  localparam logic [2:0] STEP_LAST = 3'd7;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 8-step shift-add MUL/MULS/MULSU/FMUL* sequencer driving the external ALU Adder. Rev 1.0
// Fractional multiply is built only when ALU_MUL_SEQ_FMUL_EN is defined.
`default_nettype none

module alu_mul_seq
  import alu_mul_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic             cp2,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   a_op,
  input  logic [OPW-1:0]   b_op,
  input  logic             a_signed,
  input  logic             b_signed,
  input  logic             fmul,
  output logic [2*OPW-1:0] add_a,
  output logic [2*OPW-1:0] add_b,
  output logic             add_ci,
  input  logic [2*OPW-1:0] add_s,
  input  logic             add_co,
  output logic             busy,
  output logic             done,
  output logic [2*OPW-1:0] result,
  output logic             c_flag,
  output logic             z_flag
);

  state_t             state_q;
  logic [2:0]         k_q;
  logic [2*OPW-1:0]   acc_q;
  logic [2*OPW-1:0]   mcand_q;
  logic [OPW-1:0]     mplr_q;
  logic               bsgn_q;
  logic               busy_q;
  logic               done_q;
  logic [2*OPW-1:0]   result_q;
  logic               c_q;
  logic               z_q;
  logic [2*OPW-1:0]   res_d;

  // The carry-out is not needed: every sum wraps modulo 2^(2*OPW).
  logic w_unused;
  assign w_unused = ^{add_co, fmul};

`ifdef ALU_MUL_SEQ_FMUL_EN
  logic fmul_q;
  assign res_d = fmul_q ? {add_s[2*OPW-2:0], 1'b0} : add_s;
`else
  assign res_d = add_s;
`endif

  // The final step of a signed multiplier weighs its MSB negatively, so subtract.
  always_comb begin
    add_a  = acc_q;
    add_b  = '0;
    add_ci = 1'b0;
    if (state_q == ST_CALC && mplr_q[0]) begin
      if (k_q == STEP_LAST && bsgn_q) begin
        add_b  = ~mcand_q;
        add_ci = 1'b1;
      end else begin
        add_b  = mcand_q;
      end
    end
  end

  always_ff @(posedge cp2 or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= 3'd0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      bsgn_q   <= 1'b0;
`ifdef ALU_MUL_SEQ_FMUL_EN
      fmul_q   <= 1'b0;
`endif
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_q   <= '0;
            mcand_q <= a_signed ? {{OPW{a_op[OPW-1]}}, a_op} : {{OPW{1'b0}}, a_op};
            mplr_q  <= b_op;
            bsgn_q  <= b_signed;
`ifdef ALU_MUL_SEQ_FMUL_EN
            fmul_q  <= fmul;
`endif
            k_q     <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc_q   <= add_s;
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_q >> 1;
          k_q     <= k_q + 3'd1;
          if (k_q == STEP_LAST) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= res_d;
            c_q      <= add_s[2*OPW-1];
            z_q      <= (res_d == '0);
          end
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_flag = c_q;
  assign z_flag = z_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed self-checking bench for alu_mul_seq with a behavioural 16-bit Adder.
`default_nettype none

module tb_alu_mul_seq;

  logic        cp2 = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a_op, b_op;
  logic        a_signed, b_signed, fmul;
  logic [15:0] add_a, add_b, add_s;
  logic        add_ci, add_co;
  logic        busy, done, c_flag, z_flag;
  logic [15:0] result;

  int checks   = 0;
  int failures = 0;

  always #5 cp2 = ~cp2;

  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_ci};

  alu_mul_seq dut (
    .cp2(cp2), .rst(rst), .start(start), .a_op(a_op), .b_op(b_op),
    .a_signed(a_signed), .b_signed(b_signed), .fmul(fmul),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co),
    .busy(busy), .done(done), .result(result), .c_flag(c_flag), .z_flag(z_flag)
  );

  // Launches one operation and returns at the negedge where done is seen (or after 20 cycles).
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic as,
                       input logic bs, input logic fm, output int lat, output int bcnt);
    @(negedge cp2);
    a_op = a; b_op = b; a_signed = as; b_signed = bs; fmul = fm; start = 1'b1;
    @(negedge cp2);
    start = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge cp2);
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_op = 8'h00; b_op = 8'h00;
    a_signed = 1'b0; b_signed = 1'b0; fmul = 1'b0;
    repeat (2) @(negedge cp2);
    checks++;
    if ({busy, done, c_flag, z_flag} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, c_flag, z_flag});
    end
    checks++;
    if (result !== 16'h0000) begin
      failures++; $display("FAIL reset_result: got %h expected 0000", result);
    end
    checks++;
    if ({add_a, add_b, add_ci} !== 33'd0) begin
      failures++; $display("FAIL reset_adder: got %h/%h/%b expected 0/0/0", add_a, add_b, add_ci);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int lat, bcnt;
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, lat, bcnt);
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL mul_latency: got %0d expected 8", lat); end
    checks++;
    if (bcnt !== 8) begin failures++; $display("FAIL mul_busy_cycles: got %0d expected 8", bcnt); end
    checks++;
    if ({result, c_flag, z_flag} !== {16'hFE01, 1'b1, 1'b0}) begin
      failures++; $display("FAIL mul_ff_ff: got %h C=%b Z=%b expected FE01 C=1 Z=0", result, c_flag, z_flag);
    end
    repeat (3) @(negedge cp2);
    checks++;
    if ({result, done} !== {16'hFE01, 1'b0}) begin
      failures++; $display("FAIL mul_hold: got %h done=%b expected FE01 done=0", result, done);
    end
    do_op(8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, lat, bcnt);
    checks++;
    if ({result, c_flag, z_flag} !== {16'h0000, 1'b0, 1'b1}) begin
      failures++; $display("FAIL mul_zero: got %h C=%b Z=%b expected 0000 C=0 Z=1", result, c_flag, z_flag);
    end
  endtask

  task automatic test_muls();
    int lat, bcnt;
    do_op(8'h80, 8'h80, 1'b1, 1'b1, 1'b0, lat, bcnt);
    checks++;
    if ({result, c_flag, z_flag} !== {16'h4000, 1'b0, 1'b0}) begin
      failures++; $display("FAIL muls_80_80: got %h C=%b Z=%b expected 4000 C=0 Z=0", result, c_flag, z_flag);
    end
    do_op(8'hFF, 8'h02, 1'b1, 1'b1, 1'b0, lat, bcnt);
    checks++;
    if ({result, c_flag} !== {16'hFFFE, 1'b1}) begin
      failures++; $display("FAIL muls_ff_02: got %h C=%b expected FFFE C=1", result, c_flag);
    end
  endtask

  task automatic test_mulsu();
    int lat, bcnt;
    do_op(8'h80, 8'hFF, 1'b1, 1'b0, 1'b0, lat, bcnt);
    checks++;
    if ({result, c_flag} !== {16'h8080, 1'b1}) begin
      failures++; $display("FAIL mulsu_80_ff: got %h C=%b expected 8080 C=1", result, c_flag);
    end
  endtask

  task automatic test_fmul();
    int lat, bcnt;
    logic [15:0] exp_u, exp_s;
`ifdef ALU_MUL_SEQ_FMUL_EN
    exp_u = 16'hFC02; exp_s = 16'h8000;
`else
    exp_u = 16'hFE01; exp_s = 16'h4000;
`endif
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, lat, bcnt);
    checks++;
    if ({result, c_flag} !== {exp_u, 1'b1}) begin
      failures++; $display("FAIL fmul_ff_ff: got %h C=%b expected %h C=1", result, c_flag, exp_u);
    end
    do_op(8'h80, 8'h80, 1'b1, 1'b1, 1'b1, lat, bcnt);
    checks++;
    if ({result, c_flag} !== {exp_s, 1'b0}) begin
      failures++; $display("FAIL fmuls_80_80: got %h C=%b expected %h C=0", result, c_flag, exp_s);
    end
  endtask

  task automatic test_ignore_start();
    int n_done = 0;
    int t_done = -1;
    @(negedge cp2);
    a_op = 8'h10; b_op = 8'h10; a_signed = 1'b0; b_signed = 1'b0; fmul = 1'b0; start = 1'b1;
    @(negedge cp2);
    start = 1'b0; a_op = 8'hFF; b_op = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      start = (i == 3 || i == 6);
      if (done) begin n_done++; t_done = i; end
      @(negedge cp2);
    end
    start = 1'b0;
    checks++;
    if (n_done !== 1 || t_done !== 8) begin
      failures++; $display("FAIL ignore_start_done: got count=%0d at=%0d expected count=1 at=8", n_done, t_done);
    end
    checks++;
    if (result !== 16'h0100) begin
      failures++; $display("FAIL ignore_start_result: got %h expected 0100", result);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    do_op(8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, lat, bcnt);
    checks++;
    if (result !== 16'h00E1) begin
      failures++; $display("FAIL b2b_first: got %h expected 00E1", result);
    end
    a_op = 8'h03; b_op = 8'h07; start = 1'b1;
    @(negedge cp2);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge cp2);
      lat++;
    end
    checks++;
    if (lat !== 8 || result !== 16'h0015) begin
      failures++; $display("FAIL b2b_second: got lat=%0d res=%h expected lat=8 res=0015", lat, result);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bcnt;
    int n_done = 0;
    @(negedge cp2);
    a_op = 8'h12; b_op = 8'h34; a_signed = 1'b0; b_signed = 1'b0; fmul = 1'b0; start = 1'b1;
    @(negedge cp2);
    start = 1'b0;
    repeat (4) @(negedge cp2);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, result} !== {1'b0, 1'b0, 16'h0000}) begin
      failures++; $display("FAIL abort_reset: got busy=%b done=%b res=%h expected 0 0 0000", busy, done, result);
    end
    @(negedge cp2);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge cp2);
      if (done) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      failures++; $display("FAIL abort_no_done: got %0d expected 0", n_done);
    end
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, lat, bcnt);
    checks++;
    if (lat !== 8 || result !== 16'h03A8) begin
      failures++; $display("FAIL abort_recover: got lat=%0d res=%h expected lat=8 res=03A8", lat, result);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mul();
    test_muls();
    test_mulsu();
    test_fmul();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
